// File: rtl/core_pkg.sv
// Shared core definitions: data width, NOP encoding, reset PC and the fetch pair type.
package core_pkg;

    localparam int XLEN = 32;

    // RISC-V canonical NOP (addi x0, x0, 0)
    localparam logic [XLEN-1:0] INST_NOP           = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] inst;
    } fetch_pair_t;

endpackage

// File: rtl/if_sync_fifo.sv
// Small synchronous FIFO with flush; used for the pending-address FIFO and the fetched-instruction queue.
module if_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues pipelined imem requests and pairs
// returned words with their addresses for the IF/ID register.
module if_fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDR = RESET_ADDR_DEFAULT,
    parameter int              DEPTH      = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump_flag_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            hold_flag_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_o,
    output logic            fetch_empty_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   out_cnt;
    logic [CW-1:0]   q_cnt;
    logic [XLEN-1:0] pend_addr;
    fetch_pair_t     head;
    logic            q_empty, q_pop, rvalid_live, handshake;
    logic [SW-1:0]   occupancy;
    logic            unused_jump_lsbs;

    assign unused_jump_lsbs = ^jump_addr_i[1:0];

    assign q_empty     = (q_cnt == '0);
    assign q_pop       = !hold_flag_i && !q_empty && !jump_flag_i;
    assign rvalid_live = imem_rvalid_i && (drop_cnt_q == '0) && !jump_flag_i;
    assign occupancy   = SW'(out_cnt) + SW'(drop_cnt_q) + SW'(q_cnt);

    // A head leaving this cycle frees its slot for a new request, so zero-wait memory
    // streams one word per cycle; no request is shown while reset is held.
    assign imem_req_o  = rst && !jump_flag_i && (occupancy < SW'(DEPTH) + SW'(q_pop));
    assign imem_addr_o = pc_q;
    assign handshake   = imem_req_o && imem_gnt_i;

    if_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_addr_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (handshake),
        .push_data_i (pc_q),
        .pop_i       (rvalid_live),
        .flush_i     (jump_flag_i),
        .head_o      (pend_addr),
        .count_o     (out_cnt)
    );

    if_sync_fifo #(
        .WIDTH ($bits(fetch_pair_t)),
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rvalid_live),
        .push_data_i ({pend_addr, imem_rdata_i}),
        .pop_i       (q_pop),
        .flush_i     (jump_flag_i),
        .head_o      (head),
        .count_o     (q_cnt)
    );

    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (jump_flag_i) begin
            pc_d       = {jump_addr_i[XLEN-1:2], 2'b00};
            // Responses still in flight return in order ahead of the target's, so they are squashed.
            drop_cnt_d = drop_cnt_q + out_cnt - CW'(imem_rvalid_i);
        end else begin
            if (handshake) begin
                pc_d = pc_q + 32'd4;
            end
            if (imem_rvalid_i && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_ADDR;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign fetch_empty_o = q_empty || jump_flag_i;
    assign inst_o        = fetch_empty_o ? INST_NOP : head.inst;
    assign inst_addr_o   = fetch_empty_o ? '0 : head.addr;

endmodule
